// File: rtl/fetch_unit_pkg.sv
// Shared sizing constants and types for the instruction fetch unit.
// The queue entry pairs a PC with the instruction word fetched from it.
package fetch_unit_pkg;

    localparam int ROM_DEPTH = 16;
    localparam int INSTR_W   = 32;
    localparam int QDEPTH    = 2;
    localparam int PC_W      = $clog2(ROM_DEPTH);
    localparam int QPTR_W    = $clog2(QDEPTH);
    localparam int CNT_W     = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
    } q_entry_t;

    typedef enum logic [CNT_W-1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO with push, pop and flush.
// The occupancy state doubles as the entry count.
//
// state   | meaning
// Q_EMPTY | no entries held, head invalid
// Q_ONE   | one entry held
// Q_FULL  | both entries held, push only accepted alongside a pop
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  q_entry_t         wr_entry,
    output q_entry_t         rd_entry,
    output logic [CNT_W-1:0] count
);

    q_state_e          state_q, state_d;
    logic [QPTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [QPTR_W-1:0] rd_ptr_q, rd_ptr_d;
    q_entry_t          mem_q [QDEPTH];
    q_entry_t          mem_d [QDEPTH];
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop   = pop && (state_q != Q_EMPTY) && !flush;
        do_push  = push && !flush && ((state_q != Q_FULL) || do_pop);
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;

        if (flush) begin
            state_d  = Q_EMPTY;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wr_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case (state_q)
                Q_EMPTY: if (do_push) state_d = Q_ONE;
                Q_ONE: begin
                    if (do_push && !do_pop)      state_d = Q_FULL;
                    else if (do_pop && !do_push) state_d = Q_EMPTY;
                end
                Q_FULL:  if (do_pop && !do_push) state_d = Q_ONE;
                default: state_d = Q_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= Q_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign rd_entry = mem_q[rd_ptr_q];
    assign count    = state_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: writable ROM, PC register and redirect handling
// feeding a small prefetch queue towards the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               rom_we,
    input  logic [PC_W-1:0]    rom_waddr,
    input  logic [INSTR_W-1:0] rom_wdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [PC_W-1:0]    instr_pc,
    output logic [PC_W-1:0]    fetch_pc,
    output logic [CNT_W-1:0]   queue_count
);

    logic [INSTR_W-1:0] rom_mem [ROM_DEPTH];
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               push;
    logic               pop;
    q_entry_t           wr_entry;
    q_entry_t           head;

    // ROM is deliberately not reset; writes are dropped while reset is held.
    always_ff @(posedge clk) begin
        if (reset && rom_we) begin
            rom_mem[rom_waddr] <= rom_wdata;
        end
    end

    always_comb begin
        pop           = instr_valid && instr_ready;
        push          = !redirect_valid &&
                        ((queue_count != CNT_W'(QDEPTH)) || pop);
        wr_entry.pc   = fetch_pc_q;
        wr_entry.word = rom_mem[fetch_pc_q];
        fetch_pc_d    = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue u_queue (
        .clk      (clk),
        .rst_n    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (queue_count)
    );

    assign instr_valid = (queue_count != '0);
    assign instr_data  = head.word;
    assign instr_pc    = head.pc;
    assign fetch_pc    = fetch_pc_q;

endmodule
